// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: operand-mux select
// encodings, the controller state enum, the shadow-stage payloads and the
// register-match helper.
package pipe_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned SEL_W = 2;

   // EXE operand mux select encodings
   localparam logic [SEL_W-1:0] FWD_REG = 2'b00;
   localparam logic [SEL_W-1:0] FWD_ALU = 2'b01;
   localparam logic [SEL_W-1:0] FWD_WB  = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LSTALL = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_FREEZE = 2'd3
   } hz_state_e;

   // Destination info of the instruction held in the EXE stage
   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic             regwrite;
      logic             memread;
   } ex_shadow_t;

   // Destination info of the instructions held in the MEM and WB stages
   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic             regwrite;
   } wr_shadow_t;

   // True when a source index is produced by a writing instruction; x0 never matches
   function automatic logic reg_hit(input logic [REG_W-1:0] rs,
                                    input logic [REG_W-1:0] rd,
                                    input logic             wr);
      return wr && (rd != '0) && (rs == rd);
   endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Next forward-select for one ID-stage source operand.
// Ports: rs (source index), ex_rd/ex_regwrite and mem_rd/mem_regwrite (shadow
// destinations of the two older in-flight instructions), next_sel_c (select the
// operand needs once it reaches EXE).
module fwd_sel_calc
   import pipe_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] ex_rd,
   input  logic       ex_regwrite,
   input  logic [4:0] mem_rd,
   input  logic       mem_regwrite,
   output logic [1:0] next_sel_c
);

   // The instruction now in EX will sit in MEM (ALU result bypass) when this
   // operand reaches EXE; the one now in MEM will be in WB. Youngest wins.
   always_comb begin
      next_sel_c = FWD_REG;
      if (reg_hit(rs, ex_rd, ex_regwrite)) begin
         next_sel_c = FWD_ALU;
      end else if (reg_hit(rs, mem_rd, mem_regwrite)) begin
         next_sel_c = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, memory-wait
// freeze and registered EXE operand forward selects.
// Ports: clk, rstn (synchronous active-low); id_* decode of the ID-stage
// instruction; ex_branch_taken; mem_wait; rs1/rs2_fwd_sel (registered EXE mux
// selects); pc_hold, ifid_hold, ifid_flush, idex_bubble (combinational, act in
// the detecting cycle); stall_cnt, flush_cnt (saturating event counters).
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             ex_branch_taken,
   input  logic             mem_wait,
   output logic [1:0]       rs1_fwd_sel,
   output logic [1:0]       rs2_fwd_sel,
   output logic             pc_hold,
   output logic             ifid_hold,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hz_state_e        state_q;
   hz_state_e        mode_c;
   ex_shadow_t       ex_q;
   wr_shadow_t       mem_q;
   wr_shadow_t       wb_q;
   logic [SEL_W-1:0] rs1_next_c;
   logic [SEL_W-1:0] rs2_next_c;
   logic             load_use_c;

   fwd_sel_calc u_fwd_rs1 (
      .rs           (id_rs1),
      .ex_rd        (ex_q.rd),
      .ex_regwrite  (ex_q.regwrite),
      .mem_rd       (mem_q.rd),
      .mem_regwrite (mem_q.regwrite),
      .next_sel_c   (rs1_next_c)
   );

   fwd_sel_calc u_fwd_rs2 (
      .rs           (id_rs2),
      .ex_rd        (ex_q.rd),
      .ex_regwrite  (ex_q.regwrite),
      .mem_rd       (mem_q.rd),
      .mem_regwrite (mem_q.regwrite),
      .next_sel_c   (rs2_next_c)
   );

   // ID instruction needs a value still being loaded by the EX instruction
   always_comb begin
      load_use_c = id_valid && ex_q.memread &&
                   ((id_use_rs1 && reg_hit(id_rs1, ex_q.rd, 1'b1)) ||
                    (id_use_rs2 && reg_hit(id_rs2, ex_q.rd, 1'b1)));
   end

   // Mode of the current cycle and its pipeline controls. The cycle that
   // detects an event is the stall/flush cycle itself; the state register
   // stops a one-cycle stall or flush from re-triggering on the bubble behind it.
   always_comb begin
      mode_c      = ST_RUN;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (rstn) begin
         if (mem_wait) begin
            mode_c = ST_FREEZE;
         end else if (ex_branch_taken && (state_q != ST_FLUSH)) begin
            mode_c = ST_FLUSH;
         end else if (load_use_c && (state_q != ST_LSTALL)) begin
            mode_c = ST_LSTALL;
         end
      end
      case (mode_c)
         ST_LSTALL: begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
         end
         ST_FLUSH: begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end
         ST_FREEZE: begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
         end
         default: ;
      endcase
   end

   // State, shadow stages, EXE selects and counters
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= ST_RUN;
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         rs1_fwd_sel <= FWD_REG;
         rs2_fwd_sel <= FWD_REG;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         state_q <= mode_c;
         if (mode_c != ST_FREEZE) begin
            mem_q <= '{rd: ex_q.rd, regwrite: ex_q.regwrite};
            wb_q  <= mem_q;
            if ((mode_c == ST_RUN) && id_valid) begin
               ex_q        <= '{rd: id_rd, regwrite: id_regwrite, memread: id_memread};
               rs1_fwd_sel <= rs1_next_c;
               rs2_fwd_sel <= rs2_next_c;
            end else begin
               ex_q        <= '0;
               rs1_fwd_sel <= FWD_REG;
               rs2_fwd_sel <= FWD_REG;
            end
         end
         if ((mode_c == ST_LSTALL) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if ((mode_c == ST_FLUSH) && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

   // WB shadow trails MEM by one stage; WB-vs-ID hazards are left to the regfile bypass
   wb_follows_mem: assert property (@(posedge clk) disable iff (!rstn)
      (mode_c != ST_FREEZE) |=> (wb_q == $past(mem_q)));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed cycle table, hand-written
// saturation/reset sequences and randomized traffic against a stage model.
module tb_hazard_ctrl;

   localparam int unsigned CNT_W = 4;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rstn;
   logic             id_valid;
   logic [4:0]       id_rs1, id_rs2, id_rd;
   logic             id_use_rs1, id_use_rs2, id_regwrite, id_memread;
   logic             ex_branch_taken, mem_wait;
   logic [1:0]       rs1_fwd_sel, rs2_fwd_sel;
   logic             pc_hold, ifid_hold, ifid_flush, idex_bubble;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .id_valid        (id_valid),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_rd           (id_rd),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .id_regwrite     (id_regwrite),
      .id_memread      (id_memread),
      .ex_branch_taken (ex_branch_taken),
      .mem_wait        (mem_wait),
      .rs1_fwd_sel     (rs1_fwd_sel),
      .rs2_fwd_sel     (rs2_fwd_sel),
      .pc_hold         (pc_hold),
      .ifid_hold       (ifid_hold),
      .ifid_flush      (ifid_flush),
      .idex_bubble     (idex_bubble),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit       r, v;
      int       rs1, rs2, rd;
      bit       u1, u2, wr, ld, br, mw;
      bit [3:0] ctl;      // {pc_hold, ifid_hold, ifid_flush, idex_bubble}
      int       s1, s2, sc, fc;
   } vec_t;

   // In-flight instruction as seen by the model
   typedef struct {
      bit       v;
      bit [4:0] rd;
      bit       wr;
      bit       ld;
   } ins_t;

   ins_t m_ex, m_mem;
   int   m_s1, m_s2, m_sc, m_fc;

   function automatic vec_t mk(bit r, bit v, int rs1, int rs2, int rd,
                               bit u1, bit u2, bit wr, bit ld, bit br, bit mw,
                               bit [3:0] ctl, int s1, int s2, int sc, int fc);
      vec_t t;
      t.r = r; t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
      t.u1 = u1; t.u2 = u2; t.wr = wr; t.ld = ld; t.br = br; t.mw = mw;
      t.ctl = ctl; t.s1 = s1; t.s2 = s2; t.sc = sc; t.fc = fc;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input bit r, input bit v, input int rs1, input int rs2, input int rd,
                        input bit u1, input bit u2, input bit wr, input bit ld,
                        input bit br, input bit mw);
      rstn = r; id_valid = v;
      id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
      id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = wr; id_memread = ld;
      ex_branch_taken = br; mem_wait = mw;
   endtask

   task automatic check_outs(input string p, input bit [3:0] ctl,
                             input int s1, input int s2, input int sc, input int fc);
      chk({p, " pc_hold"},     32'(pc_hold),     32'(ctl[3]));
      chk({p, " ifid_hold"},   32'(ifid_hold),   32'(ctl[2]));
      chk({p, " ifid_flush"},  32'(ifid_flush),  32'(ctl[1]));
      chk({p, " idex_bubble"}, 32'(idex_bubble), 32'(ctl[0]));
      chk({p, " rs1_fwd_sel"}, 32'(rs1_fwd_sel), 32'(s1));
      chk({p, " rs2_fwd_sel"}, 32'(rs2_fwd_sel), 32'(s2));
      chk({p, " stall_cnt"},   32'(stall_cnt),   32'(sc));
      chk({p, " flush_cnt"},   32'(flush_cnt),   32'(fc));
   endtask

   // Which older in-flight instruction supplies rs: 1 = one ahead (ALU bypass),
   // 2 = two ahead (writeback bypass), 0 = register file.
   function automatic int src_of(input bit [4:0] rs);
      ins_t ahead [2];
      ahead[0] = m_ex;
      ahead[1] = m_mem;
      if (rs == 5'd0) return 0;
      for (int d = 0; d < 2; d++) begin
         if (ahead[d].wr && (ahead[d].rd == rs)) return d + 1;
      end
      return 0;
   endfunction

   task automatic model_clear();
      m_ex  = '{1'b0, 5'd0, 1'b0, 1'b0};
      m_mem = '{1'b0, 5'd0, 1'b0, 1'b0};
      m_s1 = 0; m_s2 = 0; m_sc = 0; m_fc = 0;
   endtask

   task automatic reset_cycles();
      repeat (2) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   vec_t tbl [26];

   initial begin
      // cycle-by-cycle directed program; s/c fields are the values visible that cycle
      tbl[0]  = mk(0,0, 0, 0, 0, 0,0,0,0, 0,0, 4'b0000, 0,0,0,0);
      tbl[1]  = mk(1,1, 1, 2, 5, 1,1,1,0, 0,0, 4'b0000, 0,0,0,0); // add x5,x1,x2
      tbl[2]  = mk(1,1, 5, 1, 6, 1,1,1,0, 0,0, 4'b0000, 0,0,0,0); // add x6,x5,x1
      tbl[3]  = mk(1,0, 0, 0, 0, 0,0,0,0, 0,0, 4'b0000, 1,0,0,0);
      tbl[4]  = mk(1,1, 3, 4, 5, 1,1,1,0, 0,0, 4'b0000, 0,0,0,0); // add x5,x3,x4
      tbl[5]  = mk(1,0, 0, 0, 0, 0,0,0,0, 0,0, 4'b0000, 0,0,0,0); // nop
      tbl[6]  = mk(1,1, 5, 5, 7, 1,1,1,0, 0,0, 4'b0000, 0,0,0,0); // sub x7,x5,x5
      tbl[7]  = mk(1,0, 0, 0, 0, 0,0,0,0, 0,0, 4'b0000, 2,2,0,0);
      tbl[8]  = mk(1,1, 1, 0, 5, 1,0,1,1, 0,0, 4'b0000, 0,0,0,0); // lw x5,0(x1)
      tbl[9]  = mk(1,1, 5, 2, 6, 1,1,1,0, 0,0, 4'b1101, 0,0,0,0); // add x6,x5,x2 stalls
      tbl[10] = mk(1,1, 5, 2, 6, 1,1,1,0, 0,0, 4'b0000, 0,0,1,0); // held add
      tbl[11] = mk(1,0, 0, 0, 0, 0,0,0,0, 0,0, 4'b0000, 2,0,1,0);
      tbl[12] = mk(1,1, 0, 0, 8, 0,0,1,1, 0,0, 4'b0000, 0,0,1,0); // lw x8
      tbl[13] = mk(1,1, 8, 8, 9, 1,1,1,0, 1,0, 4'b0011, 0,0,1,0); // load-use + branch
      tbl[14] = mk(1,0, 0, 0, 0, 0,0,0,0, 0,0, 4'b0000, 0,0,1,1);
      tbl[15] = mk(1,1, 1, 1,10, 1,1,1,0, 0,0, 4'b0000, 0,0,1,1); // add x10
      tbl[16] = mk(1,1,10,10,11, 1,1,1,0, 0,0, 4'b0000, 0,0,1,1); // add x11,x10,x10
      tbl[17] = mk(1,1,11,10,12, 1,1,1,0, 0,1, 4'b1100, 1,1,1,1); // freeze x3
      tbl[18] = mk(1,1,11,10,12, 1,1,1,0, 0,1, 4'b1100, 1,1,1,1);
      tbl[19] = mk(1,1,11,10,12, 1,1,1,0, 0,1, 4'b1100, 1,1,1,1);
      tbl[20] = mk(1,1,11,10,12, 1,1,1,0, 0,0, 4'b0000, 1,1,1,1);
      tbl[21] = mk(1,1, 1, 0, 0, 1,0,1,0, 0,0, 4'b0000, 1,2,1,1); // addi x0,x1,1
      tbl[22] = mk(1,1, 0, 0,14, 1,1,1,0, 0,0, 4'b0000, 0,0,1,1); // add x14,x0,x0
      tbl[23] = mk(1,1, 1, 0, 0, 1,0,1,1, 0,0, 4'b0000, 0,0,1,1); // lw x0
      tbl[24] = mk(1,1, 0, 2,15, 1,1,1,0, 0,0, 4'b0000, 0,0,1,1); // add x15,x0,x2
      tbl[25] = mk(1,0, 0, 0, 0, 0,0,0,0, 0,0, 4'b0000, 0,0,1,1);

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset_cycles();

      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         drive(tbl[i].r, tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].u1,
               tbl[i].u2, tbl[i].wr, tbl[i].ld, tbl[i].br, tbl[i].mw);
         #1;
         check_outs($sformatf("row%0d", i), tbl[i].ctl, tbl[i].s1, tbl[i].s2,
                    tbl[i].sc, tbl[i].fc);
      end

      // stall counter saturates at all-ones without wrapping
      reset_cycles();
      for (int k = 0; k < CMAX + 2; k++) begin
         @(negedge clk);
         drive(1, 1, 1, 0, 5, 1, 0, 1, 1, 0, 0);
         @(negedge clk);
         drive(1, 1, 5, 2, 6, 1, 1, 1, 0, 0, 0);
         #1;
         chk($sformatf("sat%0d idex_bubble", k), 32'(idex_bubble), 32'd1);
         chk($sformatf("sat%0d stall_cnt", k), 32'(stall_cnt), 32'((k < CMAX) ? k : CMAX));
         @(negedge clk);
         drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      chk("sat_end stall_cnt", 32'(stall_cnt), 32'(CMAX));
      chk("frz pc_hold", 32'(pc_hold), 32'd1);

      // reset while frozen
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      chk("rst_frz pc_hold", 32'(pc_hold), 32'd0);
      chk("rst_frz ifid_hold", 32'(ifid_hold), 32'd0);
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("post_rst stall_cnt", 32'(stall_cnt), 32'd0);
      chk("post_rst pc_hold", 32'(pc_hold), 32'd0);

      // reset while a load-use is pending clears the EX shadow
      @(negedge clk);
      drive(1, 1, 1, 0, 5, 1, 0, 1, 1, 0, 0);
      @(negedge clk);
      drive(0, 1, 5, 2, 6, 1, 1, 1, 0, 0, 0);
      #1;
      chk("rst_lu idex_bubble", 32'(idex_bubble), 32'd0);
      chk("rst_lu pc_hold", 32'(pc_hold), 32'd0);
      @(negedge clk);
      drive(1, 1, 5, 2, 6, 1, 1, 1, 0, 0, 0);
      #1;
      chk("post_rst_lu idex_bubble", 32'(idex_bubble), 32'd0);
      chk("post_rst_lu stall_cnt", 32'(stall_cnt), 32'd0);

      // randomized traffic against the stage model
      reset_cycles();
      model_clear();
      for (int c = 0; c < 4000; c++) begin
         bit r, v, u1, u2, wr, ld, br, mw, frz, fl, lu;
         int rs1, rs2, rd, n1, n2;
         @(negedge clk);
         r   = ($urandom_range(0, 63) != 0);
         v   = ($urandom_range(0, 3) != 0);
         rs1 = $urandom_range(0, 7);
         rs2 = $urandom_range(0, 7);
         rd  = $urandom_range(0, 7);
         u1  = 1'($urandom_range(0, 1));
         u2  = 1'($urandom_range(0, 1));
         wr  = 1'($urandom_range(0, 1));
         ld  = ($urandom_range(0, 2) == 0);
         mw  = ($urandom_range(0, 5) == 0);
         br  = m_ex.v && ($urandom_range(0, 5) == 0);
         drive(r, v, rs1, rs2, rd, u1, u2, wr, ld, br, mw);
         frz = r && mw;
         fl  = r && !mw && br;
         lu  = r && !mw && !br && v && m_ex.ld && (m_ex.rd != 5'd0) &&
               ((u1 && (rs1 == int'(m_ex.rd))) || (u2 && (rs2 == int'(m_ex.rd))));
         #1;
         check_outs($sformatf("rand%0d", c), {frz | lu, frz | lu, fl, fl | lu},
                    m_s1, m_s2, m_sc, m_fc);
         if (!r) begin
            model_clear();
         end else if (!frz) begin
            n1 = src_of(5'(rs1));
            n2 = src_of(5'(rs2));
            m_mem = m_ex;
            if (v && !fl && !lu) begin
               m_ex = '{1'b1, 5'(rd), wr, ld};
               m_s1 = n1;
               m_s2 = n2;
            end else begin
               m_ex = '{1'b0, 5'd0, 1'b0, 1'b0};
               m_s1 = 0;
               m_s2 = 0;
            end
            if (lu && (m_sc < CMAX)) m_sc++;
            if (fl && (m_fc < CMAX)) m_fc++;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of saturating event counters.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rstn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: id_valid  in  1  ID-stage instruction valid.
REQ-005 SHALL have ports: id_rs1, id_rs2, id_rd  in  5 each  ID-stage register indices.
REQ-006 SHALL have ports: id_use_rs1, id_use_rs2, id_regwrite, id_memread  in  1 each  ID-stage decode flags.
REQ-007 SHALL have port: ex_branch_taken  in  1  EXE-stage taken branch/jump (NPCOp_new non-sequential).
REQ-008 SHALL have port: mem_wait  in  1  data memory not ready; freezes whole pipeline.
REQ-009 SHALL have ports: rs1_fwd_sel, rs2_fwd_sel  out  2 each  EXE operand mux select: 00 regfile, 01 ALU_result_Fwd, 10 WriteBackData_Fwd.
REQ-010 SHALL have ports: pc_hold, ifid_hold  out  1 each  hold PC and IF/ID register.
REQ-011 SHALL have ports: ifid_flush, idex_bubble  out  1 each  clear IF/ID; load NOP into ID/EX.
REQ-012 SHALL have ports: stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-013 SHALL keep shadow pipeline registers EX{rd,regwrite,memread}, MEM{rd,regwrite}, WB{rd,regwrite}; advanced each cycle unless frozen.
REQ-014 SHALL treat rd==0 as never matching (x0 never forwarded, never causes stall).
REQ-015 SHALL detect load-use when id_valid, EX.memread, EX.rd!=0, and (id_use_rs1 and id_rs1==EX.rd, or id_use_rs2 and id_rs2==EX.rd).
REQ-016 SHALL compute next forward select per operand at ID time: match EX.rd&EX.regwrite -> 01; else match MEM.rd&MEM.regwrite -> 10; else 00 (youngest wins).
REQ-017 SHALL register rs*_fwd_sel when the ID instruction advances into EXE, giving selects valid for the EXE instruction with zero combinational path from id_* inputs.
REQ-018 SHALL set rs*_fwd_sel to 00 when a bubble or flush enters EXE.
REQ-019 SHALL implement FSM states RUN, LSTALL, FLUSH, FREEZE.
REQ-020 RUN: load-use -> LSTALL; ex_branch_taken -> FLUSH; mem_wait -> FREEZE; all outputs deasserted otherwise.
REQ-021 LSTALL (exactly one cycle): pc_hold=ifid_hold=idex_bubble=1; EX shadow loads bubble (regwrite=memread=0); return to RUN.
REQ-022 FLUSH (exactly one cycle): ifid_flush=idex_bubble=1; EX shadow loads bubble; return to RUN.
REQ-023 FREEZE: pc_hold=ifid_hold=1, all shadow and select registers hold; stay while mem_wait; exit to RUN.
REQ-024 Hold/flush/bubble outputs SHALL be combinational from state and current inputs so they act in the detecting cycle.
REQ-025 Priority on simultaneous events: mem_wait > ex_branch_taken > load-use (branch flush discards the stalled instruction).
REQ-026 Regfile write-before-read bypass SHALL cover WB-vs-ID hazards; block does not forward from WB at ID time.
REQ-027 stall_cnt SHALL increment per LSTALL cycle, flush_cnt per FLUSH cycle; both saturate at all-ones, never wrap; hold in FREEZE.

Reset
REQ-028 On rstn==0 at clock edge: state=RUN, all shadow registers zero, rs*_fwd_sel=00, counters zero.
REQ-029 Combinational outputs SHALL be 0 while rstn==0; reset mid-stall or mid-freeze SHALL abort to RUN next cycle.

Structure
REQ-030 Shared package pipe_pkg SHALL hold FWD_REG/FWD_ALU/FWD_WB constants and the FSM state enum.
REQ-031 One sub-module fwd_sel_calc (per-operand compare, instantiated twice) SHALL produce next-select values.

Verification
REQ-032 add x5 then add x6,x5,x1 -> second instr in EXE with rs1_fwd_sel=01, rs2_fwd_sel=00.
REQ-033 add x5; nop; sub x7,x5,x5 -> sub in EXE with both selects=10.
REQ-034 lw x5 then add x6,x5,x2 -> one cycle pc_hold=ifid_hold=idex_bubble=1, then add in EXE with rs1_fwd_sel=10, stall_cnt=1.
REQ-035 ex_branch_taken=1 coincident with load-use -> ifid_flush=idex_bubble=1, no hold, flush_cnt=1, stall_cnt unchanged.
REQ-036 mem_wait high 3 cycles during forwarding -> selects and shadow hold 3 cycles, pc_hold high 3 cycles; addi x0 producer -> select 00.
REQ-037 Force stall_cnt to all-ones, trigger load-use -> counter stays all-ones; rstn=0 during FREEZE -> RUN and counters zero next cycle.
